// File: rtl/mem_responder.sv
// Latency-parameterised doubleword memory responder: one request at a time in,
// one response out, each over its own valid/ready channel.
//
// Handshakes: a transfer happens at a rising edge where valid and ready are both 1.
// The request side holds req_* stable until req_ready; the responder holds resp_*
// stable from resp_valid rising until the edge where resp_ready is also 1.
module mem_responder #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [7:0]  req_wmask,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

   localparam int unsigned WORDS  = 1 << DEPTH_LOG2;
   localparam logic [63:0] SPAN   = 64'd1 << (DEPTH_LOG2 + 3);
   localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        wen_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wmask_q;
   logic        resp_valid_q;
   logic [63:0] rdata_q;
   logic        err_q;
   logic [63:0] mem_q [WORDS];

   logic                  in_idle;
   logic                  op_wen;
   logic [63:0]           op_addr;
   logic [63:0]           op_wdata;
   logic [7:0]            op_wmask;
   logic [63:0]           offset;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  enter_resp;
   logic                  commit;

   // With LATENCY = 1 the response is formed at the acceptance edge itself, so the
   // operands come straight from the request port while idle.
   assign in_idle  = (state_q == IDLE);
   assign op_wen   = in_idle ? req_wen   : wen_q;
   assign op_addr  = in_idle ? req_addr  : addr_q;
   assign op_wdata = in_idle ? req_wdata : wdata_q;
   assign op_wmask = in_idle ? req_wmask : wmask_q;

   assign offset   = op_addr - BASE_ADDR;
   assign in_range = (offset < SPAN);
   assign idx      = offset[DEPTH_LOG2+2:3];

   // The counter is reloaded with LATENCY-1 and RESP is entered on the edge that
   // takes it to zero, which puts resp_valid exactly LATENCY cycles after acceptance.
   assign enter_resp = !rst && ((in_idle && req_valid && (LATENCY == 1)) ||
                                (state_q == BUSY && cnt_q == 4'd1));
   assign commit     = enter_resp && op_wen && in_range;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         wen_q        <= 1'b0;
         addr_q       <= 64'd0;
         wdata_q      <= 64'd0;
         wmask_q      <= 8'd0;
         resp_valid_q <= 1'b0;
         rdata_q      <= 64'd0;
         err_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  wen_q   <= req_wen;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  wmask_q <= req_wmask;
                  cnt_q   <= LAT_M1;
                  state_q <= BUSY;
               end
            end
            BUSY: cnt_q <= cnt_q - 4'd1;
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  rdata_q      <= 64'd0;
                  err_q        <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
         if (enter_resp) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            rdata_q      <= (!op_wen && in_range) ? mem_q[idx] : 64'd0;
            err_q        <= !in_range;
         end
      end
   end

   // Array is deliberately not reset; only enabled byte lanes of in-range writes land.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 8; i++) begin
            if (op_wmask[i]) mem_q[idx][8*i +: 8] <= op_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready  = in_idle && !rst;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dbg_state  = state_q;

endmodule
